qdi_1of4_sync_rx: RTL and testbench

//  Clocked consumer for a 4-phase QDI 1-of-4 channel: the downstream sink of the split/merge data output.

---
 rtl/qdi_pkg.sv | 26 ++
 rtl/qdi_rx_fifo.sv | 46 ++++
 rtl/qdi_1of4_sync_rx.sv | 113 +++++++++++
 tb/tb_qdi_1of4_sync_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdi_pkg.sv
// Shared types and helpers for the QDI 1-of-4 receiver: FSM states and rail decoding.
package qdi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VALID,
        S_WAIT_NEUTRAL
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] dec1of4(input logic [3:0] v);
        logic [1:0] d;
        d = 2'd0;
        case (v)
            4'b0010: d = 2'd1;
            4'b0100: d = 2'd2;
            4'b1000: d = 2'd3;
            default: d = 2'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/qdi_rx_fifo.sv
// Synchronous FIFO holding decoded tokens; dout is the registered head, zero while empty.
module qdi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Full is judged on registered occupancy, so a same-cycle pop never admits a push.
    assign fill      = r_wptr - r_rptr;
    assign full      = (fill == (AW + 1)'(DEPTH));
    assign empty     = (fill == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/qdi_1of4_sync_rx.sv
// Clocked sink for a 4-phase QDI 1-of-4 channel: rail synchroniser, enable handshake FSM,
// token decode into a valid/ready FIFO, accepted-token counter and sticky multi-hot error.
module qdi_1of4_sync_rx
    import qdi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [3:0]             Rx,
    output logic                   Rxe,
    output logic [1:0]             dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic [CNT_W-1:0]       tok_cnt,
    output logic                   err_multihot
);
    logic [3:0] r_sync [SYNC_STAGES];
    state_t     r_state;
    logic       r_idle_arm;
    logic       r_rxe;
    logic [CNT_W-1:0] r_tok_cnt;
    logic       r_err;

    logic [3:0] w_srx;
    logic       w_onehot;
    logic       w_multi;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'd0;
        end else begin
            r_sync[0] <= Rx;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_srx    = r_sync[SYNC_STAGES-1];
    assign w_onehot = is_onehot4(w_srx);
    assign w_multi  = (w_srx != 4'd0) && !w_onehot;
    assign w_push   = (r_state == S_WAIT_VALID) && w_onehot && !w_full;
    assign w_pop    = dout_valid && dout_ready;

    // A full FIFO leaves Rxe high, so the sender keeps its rails up until space appears.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_idle_arm <= 1'b0;
            r_rxe      <= 1'b0;
            r_tok_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idle_arm <= 1'b1;
                    if (r_idle_arm) begin
                        r_rxe   <= 1'b1;
                        r_state <= S_WAIT_VALID;
                    end
                end
                S_WAIT_VALID: begin
                    if (w_push) begin
                        r_tok_cnt <= r_tok_cnt + 1'b1;
                        r_rxe     <= 1'b0;
                        r_state   <= S_WAIT_NEUTRAL;
                    end else if (w_multi) begin
                        r_err   <= 1'b1;
                        r_rxe   <= 1'b0;
                        r_state <= S_WAIT_NEUTRAL;
                    end
                end
                S_WAIT_NEUTRAL: begin
                    if (w_srx == 4'd0) begin
                        r_rxe   <= 1'b1;
                        r_state <= S_WAIT_VALID;
                    end
                end
                default: begin
                    r_rxe   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    qdi_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dec1of4(w_srx)),
        .dout  (dout),
        .full  (w_full),
        .empty (w_empty),
        .fill  (fill)
    );

    assign dout_valid   = !w_empty;
    assign Rxe          = r_rxe;
    assign tok_cnt      = r_tok_cnt;
    assign err_multihot = r_err;

endmodule

// File: tb/tb_qdi_1of4_sync_rx.sv
// Self-checking bench: the bench acts as QDI sender and FIFO consumer; a token queue models the stream.
module tb_qdi_1of4_sync_rx;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 4;
    localparam int CNT_W       = 4;
    localparam int FW          = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       rx;
    logic             rxe;
    logic [1:0]       dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [FW-1:0]    fill;
    logic [CNT_W-1:0] tok_cnt;
    logic             err_multihot;

    int checks = 0;
    int errors = 0;
    int model_tok = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    always #5 clk = ~clk;

    qdi_1of4_sync_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .Rx           (rx),
        .Rxe          (rxe),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .fill         (fill),
        .tok_cnt      (tok_cnt),
        .err_multihot (err_multihot)
    );

    function automatic logic [3:0] rails_of(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    task automatic wait_rxe(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rxe === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Full four-phase sender handshake; called on a negedge.
    task automatic send_token(input logic [3:0] rails, output bit ok);
        bit ok1, ok2;
        rx = rails;
        wait_rxe(1'b0, 60, ok1);
        rx = 4'd0;
        wait_rxe(1'b1, 60, ok2);
        ok = ok1 && ok2;
    endtask

    // Consumer: records popped heads into got_q; mode 0 = always ready, 1 = random ready.
    task automatic collect(input int n, input int budget, input int mode);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            dout_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (dout_valid && dout_ready) got_q.push_back(dout);
        end
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d tokens, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, expected %b", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rx = 4'b0001;
        dout_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rxe !== 1'b0 || dout_valid !== 1'b0 || tok_cnt !== '0 || fill !== '0 ||
            err_multihot !== 1'b0 || dout !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: rxe=%b valid=%b tok=%0d fill=%0d err=%b dout=%b, expected all 0",
                     rxe, dout_valid, tok_cnt, fill, err_multihot, dout);
        end
        rx = 4'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rxe !== 1'b0) begin
            errors++;
            $display("FAIL reset_rxe_edge1: got %b, expected 0", rxe);
        end
        @(posedge clk); #1;
        checks++;
        if (rxe !== 1'b1) begin
            errors++;
            $display("FAIL reset_rxe_edge2: got %b, expected 1", rxe);
        end
        @(negedge clk);
        model_tok = 0;
    endtask

    task automatic test_single_token();
        bit ok;
        rx = 4'b0100;
        repeat (SYNC_STAGES) @(posedge clk);
        #1;
        checks++;
        if (rxe !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_prepush: rxe=%b valid=%b, expected 1/0", rxe, dout_valid);
        end
        @(posedge clk); #1;
        model_tok++;
        checks++;
        if (rxe !== 1'b0 || dout_valid !== 1'b1 || dout !== 2'b10 ||
            tok_cnt !== CNT_W'(model_tok) || fill !== FW'(1)) begin
            errors++;
            $display("FAIL single_push: rxe=%b valid=%b dout=%b tok=%0d fill=%0d, expected 0/1/10/%0d/1",
                     rxe, dout_valid, dout, tok_cnt, fill, CNT_W'(model_tok));
        end
        @(negedge clk);
        rx = 4'd0;
        wait_rxe(1'b1, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_rxe_return: got %b, expected 1", rxe);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || fill !== '0) begin
            errors++;
            $display("FAIL single_pop: valid=%b fill=%0d, expected 0/0", dout_valid, fill);
        end
    endtask

    task automatic test_sequence();
        bit send_ok = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
        fork
            begin
                bit ok;
                for (int i = 0; i < 16; i++) begin
                    send_token(rails_of(2'(i % 4)), ok);
                    if (!ok) send_ok = 1'b0;
                end
            end
            collect(16, 2000, 0);
        join
        model_tok += 16;
        checks++;
        if (!send_ok) begin
            errors++;
            $display("FAIL seq_handshake: got timeout, expected completion");
        end
        compare_stream("seq_data");
        checks++;
        if (tok_cnt !== CNT_W'(model_tok) || err_multihot !== 1'b0) begin
            errors++;
            $display("FAIL seq_counters: tok=%0d err=%b, expected %0d/0", tok_cnt, err_multihot, CNT_W'(model_tok));
        end
    endtask

    task automatic test_random();
        bit send_ok = 1'b1;
        logic [1:0] toks[24];
        for (int i = 0; i < 24; i++) begin
            toks[i] = 2'($urandom_range(0, 3));
            exp_q.push_back(toks[i]);
        end
        fork
            begin
                bit ok;
                for (int i = 0; i < 24; i++) begin
                    send_token(rails_of(toks[i]), ok);
                    if (!ok) send_ok = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            collect(24, 4000, 1);
        join
        model_tok += 24;
        checks++;
        if (!send_ok) begin
            errors++;
            $display("FAIL rand_handshake: got timeout, expected completion");
        end
        compare_stream("rand_data");
        checks++;
        if (tok_cnt !== CNT_W'(model_tok)) begin
            errors++;
            $display("FAIL rand_tok_cnt: got %0d, expected %0d", tok_cnt, CNT_W'(model_tok));
        end
    endtask

    task automatic test_backpressure();
        bit ok, ok_a, ok_b;
        bit send_ok = 1'b1;
        logic [1:0] toks[5];
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            toks[i] = 2'($urandom_range(0, 3));
            exp_q.push_back(toks[i]);
        end
        for (int i = 0; i < 4; i++) begin
            send_token(rails_of(toks[i]), ok);
            if (!ok) send_ok = 1'b0;
        end
        model_tok += 4;
        checks++;
        if (!send_ok || fill !== FW'(DEPTH)) begin
            errors++;
            $display("FAIL bp_fill: fill=%0d handshake_ok=%b, expected %0d/1", fill, send_ok, DEPTH);
        end
        rx = rails_of(toks[4]);
        repeat (10) @(negedge clk);
        checks++;
        if (rxe !== 1'b1 || fill !== FW'(DEPTH) || tok_cnt !== CNT_W'(model_tok)) begin
            errors++;
            $display("FAIL bp_stall: rxe=%b fill=%0d tok=%0d, expected 1/%0d/%0d",
                     rxe, fill, tok_cnt, DEPTH, CNT_W'(model_tok));
        end
        fork
            begin
                wait_rxe(1'b0, 100, ok_a);
                rx = 4'd0;
                wait_rxe(1'b1, 60, ok_b);
            end
            collect(5, 500, 0);
        join
        model_tok += 1;
        checks++;
        if (!ok_a || !ok_b) begin
            errors++;
            $display("FAIL bp_release: got handshake timeout, expected 5th token accepted");
        end
        compare_stream("bp_data");
        checks++;
        if (tok_cnt !== CNT_W'(model_tok) || fill !== '0) begin
            errors++;
            $display("FAIL bp_final: tok=%0d fill=%0d, expected %0d/0", tok_cnt, fill, CNT_W'(model_tok));
        end
    endtask

    task automatic test_multihot();
        bit ok, ok2;
        rx = 4'b0011;
        wait_rxe(1'b0, 60, ok);
        checks++;
        if (!ok || err_multihot !== 1'b1 || fill !== '0 || tok_cnt !== CNT_W'(model_tok)) begin
            errors++;
            $display("FAIL multihot_detect: rxe=%b err=%b fill=%0d tok=%0d, expected 0/1/0/%0d",
                     rxe, err_multihot, fill, tok_cnt, CNT_W'(model_tok));
        end
        rx = 4'd0;
        wait_rxe(1'b1, 60, ok);
        exp_q.push_back(2'b11);
        fork
            send_token(4'b1000, ok2);
            collect(1, 200, 0);
        join
        model_tok++;
        checks++;
        if (!ok || !ok2) begin
            errors++;
            $display("FAIL multihot_recover: got handshake timeout, expected completion");
        end
        compare_stream("multihot_next");
        checks++;
        if (err_multihot !== 1'b1 || tok_cnt !== CNT_W'(model_tok)) begin
            errors++;
            $display("FAIL multihot_sticky: err=%b tok=%0d, expected 1/%0d", err_multihot, tok_cnt, CNT_W'(model_tok));
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        rx = 4'b0010;
        wait_rxe(1'b0, 60, ok);
        checks++;
        if (!ok || fill !== FW'(1)) begin
            errors++;
            $display("FAIL midrst_setup: rxe=%b fill=%0d, expected 0/1", rxe, fill);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fill !== '0 || dout_valid !== 1'b0 || rxe !== 1'b0 || err_multihot !== 1'b0 ||
            tok_cnt !== '0 || dout !== 2'b00) begin
            errors++;
            $display("FAIL midrst_state: fill=%0d valid=%b rxe=%b err=%b tok=%0d dout=%b, expected all 0",
                     fill, dout_valid, rxe, err_multihot, tok_cnt, dout);
        end
        rx = 4'd0;
        rst_n = 1'b1;
        model_tok = 0;
        wait_rxe(1'b1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_restart: got rxe=%b, expected 1", rxe);
        end
    endtask

    initial begin
        rx = 4'd0;
        dout_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_token();
        test_sequence();
        test_random();
        test_backpressure();
        test_multihot();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
